// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver with E0/F0 prefix decode and show-ahead event FIFO.
// Define PS2_BREAK_FILTER_EN to drop break (key release) events.
module ps2_keyboard_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       iPs2Clk,
  input  logic       iPs2Data,
  input  logic       iRead,
  output logic [7:0] oKeyCode,
  output logic       oExtended,
  output logic       oBreak,
  output logic       oValid,
  output logic       oFull,
  output logic       oOverflow,
  output logic       oFrameErr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
  logic [SYNC_STAGES-1:0] sdat_q, sdat_d;
  logic                   prev_q, prev_d;
  logic                   fall;
  logic                   bit_in;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic        par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        tmo_hit;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  byte_q, byte_d;

  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic        push;
  logic        pop;
  logic        wr_en;
  logic [9:0]  entry;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [9:0]    head;

  // Shift raw lines into the synchronisers; edge detect on the last stage.
  always_comb begin
    sclk_d = {sclk_q[SYNC_STAGES-2:0], iPs2Clk};
    sdat_d = {sdat_q[SYNC_STAGES-2:0], iPs2Data};
    prev_d = sclk_q[SYNC_STAGES-1];
  end

  assign fall   = prev_q & ~sclk_q[SYNC_STAGES-1];
  assign bit_in = sdat_q[SYNC_STAGES-1];

  // Synchroniser flops idle high so reset looks like a quiet bus.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sclk_q <= '1;
      sdat_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sclk_q <= sclk_d;
      sdat_q <= sdat_d;
      prev_q <= prev_d;
    end
  end

  assign tmo_hit = (state_q != S_IDLE) &&
                   (tmo_q == TW'(TIMEOUT_CYCLES));

  // Frame state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Frame next-state: advance one step per PS/2 falling edge.
  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = S_IDLE;
    end else if (fall) begin
      unique case (state_q)
        S_IDLE:   if (!bit_in) state_d = S_DATA;
        S_DATA:   if (bcnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Frame datapath: shifting, parity/stop check, idle timeout.
  always_comb begin
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    par_d   = par_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == S_IDLE || fall) tmo_d = '0;
    else                           tmo_d = tmo_q + TW'(1);
    if (tmo_hit) begin
      tmo_d   = '0;
      err_d   = 1'b1;
      shift_d = '0;
      bcnt_d  = '0;
    end else if (fall) begin
      unique case (state_q)
        S_IDLE: begin
          bcnt_d  = '0;
          shift_d = '0;
        end
        S_DATA: begin
          shift_d = {bit_in, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
        end
        S_PARITY: par_d = bit_in;
        S_STOP: begin
          if ((^{shift_q, par_q}) && bit_in) begin
            done_d = 1'b1;
            byte_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame datapath registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      shift_q <= '0;
      bcnt_q  <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      byte_q  <= '0;
    end else begin
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      byte_q  <= byte_d;
    end
  end

  assign entry = {ext_q, brk_q, byte_q};

  // Prefix decode: E0/F0 arm flags, other bytes become events.
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    push  = 1'b0;
    if (err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (done_q) begin
      unique case (1'b1)
        (byte_q == 8'hE0): ext_d = 1'b1;
        (byte_q == 8'hF0): brk_d = 1'b1;
        default: begin
`ifdef PS2_BREAK_FILTER_EN
          push  = ~brk_q;
`else
          push  = 1'b1;
`endif
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
  end

  assign pop   = iRead & valid_q;
  assign wr_en = push & (~full_q | pop);

  // FIFO bookkeeping; a push into a full FIFO only survives alongside a pop.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q] = entry;
    wr_d = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    valid_d = (cnt_d != '0);
    full_d  = (cnt_d == CW'(FIFO_DEPTH));
    ovf_d   = ovf_q | (push & full_q & ~pop);
  end

  // Decoder flags and FIFO state registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign head      = valid_q ? mem_q[rd_q] : 10'd0;
  assign oKeyCode  = head[7:0];
  assign oExtended = head[9];
`ifdef PS2_BREAK_FILTER_EN
  assign oBreak    = 1'b0;
`else
  assign oBreak    = head[8];
`endif
  assign oValid    = valid_q;
  assign oFull     = full_q;
  assign oOverflow = ovf_q;
  assign oFrameErr = err_q;

endmodule

// File: doc/ps2_keyboard_fifo.md
# ps2_keyboard_fifo

Parametrised PS/2 keyboard receiver, successor to the first-generation scan-code receiver. Runs entirely in the system clock domain: it synchronises the PS/2 clock/data lines, deframes 11-bit frames with start/parity/stop checking and a bus-idle timeout, decodes the E0 (extended) and F0 (break) prefixes, and buffers complete key events in a show-ahead FIFO. It sits between the PS/2 pins and the display/control logic, which pops events with a read strobe.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 50000: Clock cycles without a PS/2 falling edge before a partial frame is abandoned.
- SYNC_STAGES, 2: flip-flops in each input synchroniser; ≥2.

- Clock  in  1  system clock; all logic on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- iPs2Clk  in  1  raw PS/2 clock, asynchronous.
- iPs2Data  in  1  raw PS/2 data, asynchronous.
- iRead  in  1  pop strobe; one entry per cycle while oValid=1.
- oKeyCode  out  8  scan code at FIFO head.
- oExtended  out  1  head entry was prefixed by E0.
- oBreak  out  1  head entry was prefixed by F0 (key release).
- oValid  out  1  FIFO not empty.
- oFull  out  1  FIFO holds FIFO_DEPTH entries.
- oOverflow  out  1  sticky: an event was dropped because FIFO was full.
- oFrameErr  out  1  one-cycle pulse on parity, stop-bit or timeout error.

## Operation
- Both inputs pass through SYNC_STAGES flops; falling edge of iPs2Clk = synchronised value 1 then 0 on consecutive cycles. Data sampled on that edge only.
- Frame FSM: IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: falling edge with data=0 → DATA, bit counter 0; data=1 → stay IDLE (glitch ignored).
  - DATA: shift in LSB first; after 8th bit → PARITY.
  - PARITY: record bit; odd parity over 8 data bits + parity required.
  - STOP: stop bit must be 1. Parity ok and stop=1 → byte complete; else pulse oFrameErr. Always → IDLE.
- Timeout: counter cleared on every falling edge and in IDLE; in any other state, reaching TIMEOUT_CYCLES forces IDLE, discards shift register, pulses oFrameErr.
- Decoder on complete byte: 0xE0 sets ext flag; 0xF0 sets brk flag; neither pushed. Any other byte pushes {ext, brk, byte} and clears both flags. oFrameErr also clears both flags.
- FIFO: 10-bit entries, show-ahead; oKeyCode/oExtended/oBreak show head, all 0 when empty.
  - Pop when iRead & oValid; iRead when empty ignored.
  - Push when full without same-cycle pop: entry dropped, oOverflow set; held until reset.
  - Push and pop same cycle: both take effect, count unchanged, including when full.
- Reset_n low (at any time, including mid-frame): FSM IDLE, counters, flags, FIFO pointers cleared; all outputs 0; synchronisers load 1 (idle bus).

## Timing
- Stop-bit falling edge on iPs2Clk → oValid (FIFO previously empty) high exactly SYNC_STAGES + 2 Clock cycles after the first Clock edge sampling iPs2Clk low.
- oFrameErr: exactly one cycle, same cycle a push would have occurred (stop error) or the cycle after the counter reaches TIMEOUT_CYCLES.
- Pop: head advances on the Clock edge where iRead & oValid; new head visible next cycle. oValid/oFull are registered count flags.
- Minimum supported PS/2 half-period: SYNC_STAGES + 2 Clock cycles.

## Configuration
- PS2_BREAK_FILTER_EN defined: events with brk flag set are discarded, not pushed (flags still cleared); oBreak tied 0. FIFO holds make codes only.
- Not defined: break events pushed with oBreak=1 as described above.

## Test plan
- Frame 0x1C, parity 0, stop 1 → oValid=1, oKeyCode=0x1C, oExtended=0, oBreak=0; iRead → oValid=0.
- Frames E0, F0, 75 (macro off) → single entry oKeyCode=0x75, oExtended=1, oBreak=1; macro on → no entry, oValid stays 0.
- Frame 0x1C with parity 1 → no push, oFrameErr one-cycle pulse; following frame 0x29 → oKeyCode=0x29, flags 0.
- Start + 5 data bits, bus idle TIMEOUT_CYCLES+10 cycles → oFrameErr pulse, FSM IDLE; next frame 0x15 received correctly.
- FIFO_DEPTH+1 frames 0x01..0x09 (depth 8) without reads → oFull=1, oOverflow=1; 8 pops return 0x01..0x08 in order, 0x09 lost.
- Reset_n low after 4 data bits of a frame, released → all outputs 0; next frame 0x1C received correctly.
